// File: rtl/ps2_mouse_host.sv
// PS/2 host-side mouse controller.
// Enables data reporting (0xF4) after reset, then assembles 3-byte stream
// packets into a 25-bit bus whose bit 24 toggles once per complete packet.
module ps2_mouse_host #(
    parameter int unsigned INHIBIT_CYCLES = 2800,
    parameter int unsigned TIMEOUT_CYCLES = 56000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    output logic [24:0] ps2_mouse,
    output logic        init_done
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK_BYTE   = 8'hFA;

    localparam logic [2:0] S_INHIBIT  = 3'd0;
    localparam logic [2:0] S_RTS      = 3'd1;
    localparam logic [2:0] S_TX       = 3'd2;
    localparam logic [2:0] S_TX_ACK   = 3'd3;
    localparam logic [2:0] S_WAIT_FA  = 3'd4;
    localparam logic [2:0] S_STREAM   = 3'd5;
    localparam logic [2:0] S_ERR_WAIT = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic [9:0]    tx_sr;
    logic [3:0]    tx_cnt;
    logic [9:0]    rx_sr;
    logic [3:0]    rx_cnt;
    logic [1:0]    idx;
    logic [7:0]    byte0;
    logic [7:0]    byte1;

    logic          fall;
    logic          bit_in;
    logic [10:0]   frame;
    logic          frame_ok;
    logic [7:0]    rx_byte;
    logic          rx_last;
    logic          cnt_timeout;

    // Two-flop synchronizers plus a delayed copy of the clock for edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_sync[1];
        end
    end

    // Edge detect and frame decode; the 11th bit is taken straight from the pin
    always_comb begin
        fall        = clk_prev & ~clk_sync[1];
        bit_in      = dat_sync[1];
        frame       = {bit_in, rx_sr};
        frame_ok    = ~frame[0] & frame[10] & (^frame[9:1]);
        rx_byte     = frame[8:1];
        rx_last     = (rx_cnt == 4'd10);
        cnt_timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
    end

    // Init handshake, frame reception and packet assembly
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_INHIBIT;
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            ps2_mouse  <= '0;
            init_done  <= 1'b0;
            tx_sr      <= '0;
            tx_cnt     <= '0;
            rx_sr      <= '0;
            rx_cnt     <= '0;
            idx        <= '0;
            byte0      <= '0;
            byte1      <= '0;
        end else begin
            case (state)
                S_INHIBIT: begin
                    ps2_clk_oe <= 1'b1;
                    ps2_dat_oe <= 1'b0;
                    if (cnt == CW'(INHIBIT_CYCLES)) begin
                        ps2_dat_oe <= 1'b1;
                        cnt        <= '0;
                        state      <= S_RTS;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RTS: begin
                    // Start bit stays driven; releasing the clock hands it to the device
                    ps2_clk_oe <= 1'b0;
                    tx_sr      <= {1'b1, ~^CMD_ENABLE, CMD_ENABLE};
                    tx_cnt     <= '0;
                    cnt        <= '0;
                    state      <= S_TX;
                end
                S_TX: begin
                    if (fall) begin
                        ps2_dat_oe <= ~tx_sr[0];
                        tx_sr      <= {1'b1, tx_sr[9:1]};
                        tx_cnt     <= tx_cnt + 4'd1;
                        cnt        <= '0;
                        if (tx_cnt == 4'd9) begin
                            state <= S_TX_ACK;
                        end
                    end else if (cnt_timeout) begin
                        ps2_dat_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= S_ERR_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_TX_ACK: begin
                    if (fall) begin
                        cnt    <= '0;
                        rx_cnt <= '0;
                        state  <= bit_in ? S_ERR_WAIT : S_WAIT_FA;
                    end else if (cnt_timeout) begin
                        cnt   <= '0;
                        state <= S_ERR_WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_FA, S_STREAM: begin
                    if (fall) begin
                        cnt <= '0;
                        if (rx_last) begin
                            rx_cnt <= '0;
                            if (state == S_WAIT_FA) begin
                                if (frame_ok && rx_byte == ACK_BYTE) begin
                                    init_done <= 1'b1;
                                    idx       <= '0;
                                    state     <= S_STREAM;
                                end else begin
                                    state <= S_ERR_WAIT;
                                end
                            end else if (!frame_ok) begin
                                idx <= '0;
                            end else begin
                                // Bit 3 is always set in a first packet byte; use it to resync
                                case (idx)
                                    2'd0: begin
                                        if (rx_byte[3]) begin
                                            byte0 <= rx_byte;
                                            idx   <= 2'd1;
                                        end
                                    end
                                    2'd1: begin
                                        byte1 <= rx_byte;
                                        idx   <= 2'd2;
                                    end
                                    default: begin
                                        ps2_mouse <= {~ps2_mouse[24], rx_byte, byte1, byte0};
                                        idx       <= 2'd0;
                                    end
                                endcase
                            end
                        end else begin
                            rx_sr  <= {bit_in, rx_sr[9:1]};
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end else if (state == S_STREAM && rx_cnt == 4'd0) begin
                        // Idle between frames: the timeout only guards a frame in progress
                        cnt <= '0;
                    end else if (cnt_timeout) begin
                        cnt    <= '0;
                        rx_cnt <= '0;
                        if (state == S_WAIT_FA) begin
                            state <= S_ERR_WAIT;
                        end else begin
                            idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ERR_WAIT: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (cnt_timeout) begin
                        cnt   <= '0;
                        state <= S_INHIBIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    cnt        <= '0;
                    state      <= S_INHIBIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_host.sv
// Directed bench for ps2_mouse_host with an open-collector PS/2 mouse model.
module tb_ps2_mouse_host;

    localparam int unsigned INH  = 40;
    localparam int unsigned TMO  = 400;
    localparam int unsigned HALF = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_dat = 1'b1;
    logic        ps2_clk_line;
    logic        ps2_dat_line;
    logic        ps2_clk_oe;
    logic        ps2_dat_oe;
    logic [24:0] ps2_mouse;
    logic        init_done;

    int tests = 0;
    int fails = 0;
    int toggles = 0;
    int bad_upd = 0;
    logic [24:0] prev_mouse = '0;

    // Wired-AND bus: either side may pull a line low
    assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_line = dev_dat & ~ps2_dat_oe;

    ps2_mouse_host #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk_in(ps2_clk_line),
        .ps2_dat_in(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .ps2_mouse (ps2_mouse),
        .init_done (init_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Count packet toggles and flag payload changes that arrive without one
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (ps2_mouse[24] !== prev_mouse[24]) toggles <= toggles + 1;
            else if (ps2_mouse[23:0] !== prev_mouse[23:0]) bad_upd <= bad_upd + 1;
        end
        prev_mouse <= ps2_mouse;
    end

    // Backstop in case a bounded wait is ever miscounted
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dev_pulse();
        @(negedge clk_sys);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk_sys);
    endtask

    // Device-to-host: first nbits of an 11-bit frame, LSB (start) first
    task automatic dev_send_bits(input logic [10:0] frm, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            dev_dat = frm[i];
            repeat (2) @(negedge clk_sys);
            dev_pulse();
        end
        dev_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic [10:0] frm;
        frm = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        dev_send_bits(frm, 11);
        repeat (6) @(negedge clk_sys);
    endtask

    // Host-to-device: device clocks 10 bits, reading each on the rising edge
    task automatic dev_read_host(output logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk_sys);
            bits[i] = ps2_dat_line;
            repeat (HALF / 2) @(negedge clk_sys);
        end
    endtask

    task automatic init_handshake(input string pfx, input logic [7:0] resp);
        int n;
        logic [9:0] bits;
        n = 0;
        while (!ps2_clk_oe && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check({pfx, "_inhibit_seen"}, 32'(ps2_clk_oe), 32'd1);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 1000) begin
            n++;
            @(negedge clk_sys);
        end
        check({pfx, "_inhibit_len"}, 32'(n), 32'(INH));
        check({pfx, "_rts_oe"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'b11);
        @(negedge clk_sys);
        check({pfx, "_tx_start_oe"}, 32'({ps2_clk_oe, ps2_dat_oe, ps2_dat_line}), 32'b010);
        dev_read_host(bits);
        // 0xF4 carries five ones, so the odd parity bit is 0; stop reads back released
        check({pfx, "_tx_bits"}, 32'(bits), 32'h2F4);
        @(negedge clk_sys);
        dev_dat = 1'b0;
        repeat (2) @(negedge clk_sys);
        dev_pulse();
        dev_dat = 1'b1;
        check({pfx, "_pre_resp_init"}, 32'(init_done), 32'd0);
        repeat (20) @(negedge clk_sys);
        send_byte(resp, 1'b0);
        repeat (10) @(negedge clk_sys);
    endtask

    initial begin
        int t0;
        int n;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_mouse", 32'(ps2_mouse), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        reset_n = 1'b1;

        // Rejected init, then retry succeeds
        init_handshake("init_fe", 8'hFE);
        check("fe_init_done", 32'(init_done), 32'd0);
        check("fe_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
        init_handshake("init_retry", 8'hFA);
        check("retry_init_done", 32'(init_done), 32'd1);

        // Stream packets
        t0 = toggles;
        send_byte(8'h09, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'hFB, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("pkt1_value", 32'(ps2_mouse), 32'h1FB0509);
        check("pkt1_toggles", 32'(toggles - t0), 32'd1);

        t0 = toggles;
        send_byte(8'h08, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("pkt2_value", 32'(ps2_mouse), 32'h0000008);
        check("pkt2_toggles", 32'(toggles - t0), 32'd1);

        // Bad parity drops the partial packet
        t0 = toggles;
        send_byte(8'h08, 1'b0); send_byte(8'h10, 1'b1);
        send_byte(8'h08, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("perr_value", 32'(ps2_mouse), 32'h1201008);
        check("perr_toggles", 32'(toggles - t0), 32'd1);

        // Stray byte without bit 3 is skipped
        t0 = toggles;
        send_byte(8'h00, 1'b0);
        send_byte(8'h0A, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("resync_value", 32'(ps2_mouse), 32'h002010A);
        check("resync_toggles", 32'(toggles - t0), 32'd1);

        // Truncated frame: 5 bits of byte 1, then silence past the timeout
        t0 = toggles;
        send_byte(8'h08, 1'b0);
        dev_send_bits({1'b1, 1'b0, 8'h10, 1'b0}, 5);
        repeat (TMO + 50) @(negedge clk_sys);
        check("tmo_no_update", 32'(toggles - t0), 32'd0);
        send_byte(8'h0C, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("tmo_value", 32'(ps2_mouse), 32'h104030C);
        check("tmo_toggles", 32'(toggles - t0), 32'd1);
        check("stream_init_done", 32'(init_done), 32'd1);
        check("stream_no_drive", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);

        // Reset pulsed while the host is transmitting
        @(negedge clk_sys);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        n = 0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        dev_pulse();
        dev_pulse();
        check("midtx_dat_driven", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("midtx_rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
        check("midtx_rst_mouse", 32'(ps2_mouse), 32'd0);
        check("midtx_rst_init", 32'(init_done), 32'd0);
        repeat (4) @(negedge clk_sys);
        reset_n = 1'b1;
        init_handshake("reinit", 8'hFA);
        check("reinit_init_done", 32'(init_done), 32'd1);

        t0 = toggles;
        send_byte(8'h18, 1'b0); send_byte(8'h7F, 1'b0); send_byte(8'h80, 1'b0);
        repeat (10) @(negedge clk_sys);
        check("pkt_after_reinit", 32'(ps2_mouse), 32'h1807F18);
        check("pkt_after_reinit_toggles", 32'(toggles - t0), 32'd1);
        check("no_untoggled_updates", 32'(bad_upd), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
